data_cache: RTL and testbench



---
 rtl/data_cache_if.sv | 30 +++
 rtl/data_cache.sv | 158 +++++++++++++++
 tb/tb_data_cache.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Pipeline-side and backing-memory-side signals of the data cache, grouped as one bus.
// Handshake: the cache holds mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb stable until memory returns a one-cycle mem_ready pulse; stallM holds the pipeline meanwhile.
interface data_cache_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] aluresultM;
    logic [DATA_WIDTH-1:0] writedataM;
    logic                  memwriteM;
    logic                  memreadM;
    logic [2:0]            funct3M;
    logic [DATA_WIDTH-1:0] readdataM;
    logic                  stallM;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  aluresultM, writedataM, memwriteM, memreadM, funct3M, mem_ready, mem_rdata,
        output readdataM, stallM, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output aluresultM, writedataM, memwriteM, memreadM, funct3M, mem_ready, mem_rdata,
        input  readdataM, stallM, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load hits return combinationally; read misses and all stores stall until mem_ready.
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8
) (
    input  logic           clk,
    input  logic           rst,
    data_cache_if.slave    bus,
    output logic [1:0]     dbg_state
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = DATA_WIDTH - IDX - 2;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [2:0]            f3_q, f3_d;
    logic [SETS-1:0]       valid_q, valid_d;
    logic [TAGW-1:0]       tag_q [SETS];
    logic [TAGW-1:0]       tag_d [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];
    logic [DATA_WIDTH-1:0] data_d [SETS];

    logic [IDX-1:0]        req_idx, lat_idx;
    logic [TAGW-1:0]       req_tag, lat_tag;
    logic                  req_hit, lat_hit;

    function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0] off,
                                                      input logic [2:0] f3);
        logic [7:0] b;
        b = word[8*off +: 8];
        case (f3)
            3'b000:  fmt_load = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, b};
            default: fmt_load = word;
        endcase
    endfunction

    assign req_idx = bus.aluresultM[IDX+1:2];
    assign req_tag = bus.aluresultM[DATA_WIDTH-1:IDX+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lat_idx = addr_q[IDX+1:2];
    assign lat_tag = addr_q[DATA_WIDTH-1:IDX+2];
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign dbg_state     = state_q;

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        f3_d          = f3_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        bus.stallM    = 1'b0;
        bus.readdataM = '0;
        case (state_q)
            IDLE: begin
                if (bus.memreadM) begin
                    if (req_hit) begin
                        bus.readdataM = fmt_load(data_q[req_idx], bus.aluresultM[1:0], bus.funct3M);
                    end else begin
                        bus.stallM = 1'b1;
                        addr_d     = bus.aluresultM;
                        f3_d       = bus.funct3M;
                        wstrb_d    = 4'b0000;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        state_d    = FILL;
                    end
                end else if (bus.memwriteM) begin
                    bus.stallM = 1'b1;
                    addr_d     = bus.aluresultM;
                    f3_d       = bus.funct3M;
                    // SB replicates the byte so every lane carries it; the strobe picks the lane.
                    if (bus.funct3M == 3'b000) begin
                        wdata_d = {4{bus.writedataM[7:0]}};
                        wstrb_d = 4'b0001 << bus.aluresultM[1:0];
                    end else begin
                        wdata_d = bus.writedataM;
                        wstrb_d = 4'b1111;
                    end
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    state_d   = WRITE;
                end
            end
            FILL: begin
                bus.stallM = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    bus.readdataM    = fmt_load(bus.mem_rdata, addr_q[1:0], f3_q);
                    valid_d[lat_idx] = 1'b1;
                    tag_d[lat_idx]   = lat_tag;
                    data_d[lat_idx]  = bus.mem_rdata;
                    mem_req_d        = 1'b0;
                    state_d          = IDLE;
                end
            end
            WRITE: begin
                bus.stallM = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    if (lat_hit) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) data_d[lat_idx][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wstrb_d   = 4'b0000;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            f3_q      <= 3'b000;
            valid_q   <= '0;
            tag_q     <= '{default: '0};
            data_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            f3_q      <= f3_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a latency-programmable memory model plus
// scenario tasks that compare loads against an expected-data queue.
module tb_data_cache;
    logic clk;
    logic rst;
    logic [1:0] dbg_state;

    data_cache_if #(.DATA_WIDTH(32)) bus ();

    data_cache #(.DATA_WIDTH(32), .SETS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int mem_lat = 3;
    logic [31:0] mem_words [256];
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: answers a request after mem_lat cycles of mem_req with a one-cycle mem_ready.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            if (rst || !bus.mem_req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt = 0;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_wstrb[b])
                                mem_words[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                    end else begin
                        bus.mem_rdata = mem_words[bus.mem_addr[9:2]];
                    end
                end
            end
        end
    end

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [7:0] b;
        b = w[8*off +: 8];
        if (f3 == 3'b000) return {{24{b[7]}}, b};
        if (f3 == 3'b100) return {24'h0, b};
        return w;
    endfunction

    // Driver: presents one access and waits (bounded) for stallM to drop.
    task automatic do_access(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, output logic [31:0] data, output int cycles,
                             output logic [31:0] req_addr, output logic [3:0] req_strb,
                             output logic [31:0] req_wdata, output logic req_we);
        logic seen;
        seen = 1'b0;
        data = 'x; req_addr = 'x; req_strb = 'x; req_wdata = 'x; req_we = 'x;
        @(posedge clk);
        #1;
        bus.memreadM   = rd;
        bus.memwriteM  = ~rd;
        bus.aluresultM = addr;
        bus.writedataM = wd;
        bus.funct3M    = f3;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.mem_req && !seen) begin
                seen = 1'b1;
                req_addr = bus.mem_addr; req_strb = bus.mem_wstrb;
                req_wdata = bus.mem_wdata; req_we = bus.mem_we;
            end
            if (!bus.stallM) begin
                data = bus.readdataM;
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        bus.memreadM  = 1'b0;
        bus.memwriteM = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.stallM !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stallM); end
        total++; if (bus.readdataM !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.readdataM); end
        total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_req got=%b%b exp=00", bus.mem_req, bus.mem_we); end
        total++; if (bus.mem_wstrb !== 4'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0/0/0", bus.mem_wstrb, bus.mem_addr, bus.mem_wdata); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_load_miss();
        logic [31:0] d, ra, rw; logic [3:0] rs; logic we; int cyc;
        mem_lat = 3;
        exp_q.push_back(32'hDEADBEEF);
        do_access(1'b1, 32'h100, 32'h0, 3'b010, d, cyc, ra, rs, rw, we);
        total++; if (cyc !== 4) begin bad++; $display("FAIL miss_cycles got=%0d exp=4", cyc); end
        total++; if (ra !== 32'h100 || we !== 1'b0 || rs !== 4'h0) begin bad++; $display("FAIL miss_req got=%h/%b/%h exp=00000100/0/0", ra, we, rs); end
        total++; begin logic [31:0] e; e = exp_q.pop_front(); if (d !== e) begin bad++; $display("FAIL miss_data got=%h exp=%h", d, e); end end
        exp_q.push_back(32'hDEADBEEF);
        do_access(1'b1, 32'h100, 32'h0, 3'b010, d, cyc, ra, rs, rw, we);
        total++; if (cyc !== 1) begin bad++; $display("FAIL rehit_cycles got=%0d exp=1", cyc); end
        total++; begin logic [31:0] e; e = exp_q.pop_front(); if (d !== e) begin bad++; $display("FAIL rehit_data got=%h exp=%h", d, e); end end
    endtask

    task automatic test_byte_loads();
        logic [31:0] d, ra, rw; logic [3:0] rs; logic we; int cyc;
        logic [31:0] addrs [3] = '{32'h103, 32'h103, 32'h100};
        logic [2:0]  f3s   [3] = '{3'b000, 3'b100, 3'b000};
        exp_q.push_back(32'hFFFFFFDE); exp_q.push_back(32'h000000DE); exp_q.push_back(32'hFFFFFFEF);
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, addrs[i], 32'h0, f3s[i], d, cyc, ra, rs, rw, we);
            total++; if (cyc !== 1) begin bad++; $display("FAIL byte_cycles[%0d] got=%0d exp=1", i, cyc); end
            total++; begin logic [31:0] e; e = exp_q.pop_front(); if (d !== e) begin bad++; $display("FAIL byte_data[%0d] got=%h exp=%h", i, d, e); end end
        end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] off; logic [2:0] f3; int k;
            off = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 2);
            f3 = (k == 0) ? 3'b000 : (k == 1) ? 3'b100 : 3'b010;
            exp_q.push_back(load_model(32'hDEADBEEF, off, f3));
            do_access(1'b1, {30'h40, off}, 32'h0, f3, d, cyc, ra, rs, rw, we);
            total++; begin logic [31:0] e; e = exp_q.pop_front();
                if (d !== e || cyc !== 1) begin bad++; $display("FAIL rand_load[%0d] got=%h/%0d exp=%h/1", i, d, cyc, e); end end
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] d, ra, rw; logic [3:0] rs; logic we; int cyc;
        mem_lat = 2;
        do_access(1'b0, 32'h101, 32'hAABBCC55, 3'b000, d, cyc, ra, rs, rw, we);
        total++; if (cyc !== 3) begin bad++; $display("FAIL sb_cycles got=%0d exp=3", cyc); end
        total++; if (rs !== 4'b0010 || rw !== 32'h55555555 || we !== 1'b1 || ra !== 32'h100) begin
            bad++; $display("FAIL sb_req got=%h/%h/%b/%h exp=2/55555555/1/00000100", rs, rw, we, ra); end
        exp_q.push_back(32'hDEAD55EF);
        do_access(1'b1, 32'h100, 32'h0, 3'b010, d, cyc, ra, rs, rw, we);
        total++; begin logic [31:0] e; e = exp_q.pop_front();
            if (d !== e || cyc !== 1) begin bad++; $display("FAIL sb_merge got=%h/%0d exp=%h/1", d, cyc, e); end end
    endtask

    task automatic test_store_miss();
        logic [31:0] d, ra, rw; logic [3:0] rs; logic we; int cyc;
        mem_lat = 2;
        do_access(1'b0, 32'h200, 32'hCAFEF00D, 3'b010, d, cyc, ra, rs, rw, we);
        total++; if (cyc !== 3 || rs !== 4'hF || ra !== 32'h200 || rw !== 32'hCAFEF00D) begin
            bad++; $display("FAIL sw_req got=%0d/%h/%h/%h exp=3/f/00000200/cafef00d", cyc, rs, ra, rw); end
        exp_q.push_back(32'hCAFEF00D);
        do_access(1'b1, 32'h200, 32'h0, 3'b010, d, cyc, ra, rs, rw, we);
        total++; if (cyc !== 3) begin bad++; $display("FAIL no_alloc_cycles got=%0d exp=3", cyc); end
        total++; begin logic [31:0] e; e = exp_q.pop_front(); if (d !== e) begin bad++; $display("FAIL no_alloc_data got=%h exp=%h", d, e); end end
    endtask

    task automatic test_back_to_back_conflict();
        logic [31:0] d, ra, rw; logic [3:0] rs; logic we; int cyc;
        logic [31:0] seq [3] = '{32'h120, 32'h100, 32'h120};
        mem_lat = 1;
        exp_q.push_back(32'h11112222); exp_q.push_back(32'hDEAD55EF); exp_q.push_back(32'h11112222);
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, seq[i], 32'h0, 3'b010, d, cyc, ra, rs, rw, we);
            total++; begin logic [31:0] e; e = exp_q.pop_front();
                if (d !== e || cyc !== 2 || ra !== seq[i]) begin
                    bad++; $display("FAIL conflict[%0d] got=%h/%0d/%h exp=%h/2/%h", i, d, cyc, ra, e, seq[i]); end end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d, ra, rw; logic [3:0] rs; logic we; int cyc;
        mem_lat = 8;
        @(posedge clk);
        #1;
        bus.memreadM = 1'b1; bus.memwriteM = 1'b0; bus.aluresultM = 32'h104; bus.funct3M = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.memreadM = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL pre_rst_req got=%b exp=1", bus.mem_req); end
        rst = 1'b1;
        #1;
        total++; if (bus.mem_req !== 1'b0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL rst_abort got=%b/%0d exp=0/0", bus.mem_req, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 2;
        exp_q.push_back(32'hDEADBEEF);
        do_access(1'b1, 32'h120, 32'h0, 3'b000, d, cyc, ra, rs, rw, we);
        exp_q.pop_front();
        total++; if (cyc !== 3) begin bad++; $display("FAIL invalidated_cycles got=%0d exp=3", cyc); end
        total++; if (d !== 32'h00000022) begin bad++; $display("FAIL invalidated_data got=%h exp=00000022", d); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
        mem_words[8'h40] = 32'hDEADBEEF;
        mem_words[8'h48] = 32'h11112222;
        bus.memreadM = 1'b0; bus.memwriteM = 1'b0; bus.aluresultM = '0;
        bus.writedataM = '0; bus.funct3M = 3'b010;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_load_miss();
        test_byte_loads();
        test_store_hit();
        test_store_miss();
        test_back_to_back_conflict();
        test_reset_mid_fill();
        idle_cycle();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
